// File: rtl/seg7_reader.sv
// seg7_reader: recovers BCD digits from a multiplexed active-low
// 7-segment bus and emits one packed HH:MM word per complete frame.
module seg7_reader #(
  parameter int STABLE = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [6:0]  nSEG,
  input  logic [3:0]  nDIG,
  input  logic        CLR,
  output logic [15:0] DOUT,
  output logic [3:0]  BLANK,
  output logic        VALID,
  output logic        ERR
);

  localparam logic [1:0] WAIT0 = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [7:0] STB   = 8'(STABLE);

  logic [6:0]  segS1, segS2, segP;
  logic [3:0]  digS1, digS2, digP;
  logic [7:0]  cnt, cntNxt;
  logic        used, usedNxt;
  logic        idle, multi, oneHot, change, accept;
  logic [3:0]  code, selBit, newMask;
  logic        isBlank, isValid;
  logic [1:0]  idx;
  logic [1:0]  state;
  logic [3:0]  mask;
  logic [15:0] shadow;
  logic [3:0]  shBlank;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      segS1 <= '1;
      segS2 <= '1;
      digS1 <= '1;
      digS2 <= '1;
    end else begin
      segS1 <= nSEG;
      segS2 <= segS1;
      digS1 <= nDIG;
      digS2 <= digS1;
    end
  end

  assign idle   = &digS2;
  assign multi  = !idle && (((~digS2) & ((~digS2) - 4'd1)) != 4'd0);
  assign oneHot = !idle && !multi;
  assign change = {digS2, segS2} != {digP, segP};

  always_comb begin
    cntNxt  = cnt;
    usedNxt = used;
    if (!oneHot) begin
      cntNxt  = 8'd0;
      usedNxt = 1'b0;
    end else if (change) begin
      cntNxt  = 8'd1;
      usedNxt = 1'b0;
    end else if (cnt < STB) begin
      cntNxt = cnt + 8'd1;
    end
  end

  assign accept = oneHot && (cntNxt == STB) && !usedNxt;

  always_comb begin
    idx = 2'd0;
    if (oneHot) begin
      unique case (1'b1)
        !digS2[0]: idx = 2'd0;
        !digS2[1]: idx = 2'd1;
        !digS2[2]: idx = 2'd2;
        !digS2[3]: idx = 2'd3;
        default:   idx = 2'd0;
      endcase
    end
  end

  always_comb begin
    code    = 4'd0;
    isBlank = 1'b0;
    isValid = 1'b1;
    case (segS2)
      7'b1000000: code = 4'd0;
      7'b1111001: code = 4'd1;
      7'b0100100: code = 4'd2;
      7'b0110000: code = 4'd3;
      7'b0011001: code = 4'd4;
      7'b0010010: code = 4'd5;
      7'b0000010: code = 4'd6;
      7'b1011000: code = 4'd7;
      7'b0000000: code = 4'd8;
      7'b0010000: code = 4'd9;
      7'b1111111: isBlank = 1'b1;
      default:    isValid = 1'b0;
    endcase
  end

  assign selBit  = 4'b0001 << idx;
  assign newMask = mask | selBit;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      digP    <= '1;
      segP    <= '1;
      cnt     <= '0;
      used    <= 1'b0;
      state   <= WAIT0;
      mask    <= '0;
      shadow  <= '0;
      shBlank <= '0;
      DOUT    <= '0;
      BLANK   <= '0;
      VALID   <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      digP  <= digS2;
      segP  <= segS2;
      cnt   <= cntNxt;
      used  <= usedNxt | accept;
      VALID <= 1'b0;
      if (multi || (accept && !isValid)) ERR <= 1'b1;
      else if (CLR)                      ERR <= 1'b0;
      // Write the shadow only where the frame FSM is listening
      if (accept && isValid &&
          ((state == SCAN) || (state == WAIT0 && idx == 2'd0))) begin
        shadow[{idx, 2'b00} +: 4] <= isBlank ? 4'd0 : code;
        shBlank[idx]              <= isBlank;
      end
      case (state)
        WAIT0: begin
          if (accept && isValid && idx == 2'd0) begin
            mask  <= 4'b0001;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (accept && isValid) begin
            if (idx == 2'd0) begin
              mask <= 4'b0001;
            end else begin
              mask <= newMask;
              if (newMask == 4'b1111) state <= DONE;
            end
          end
        end
        DONE: begin
          DOUT  <= shadow;
          BLANK <= shBlank;
          VALID <= 1'b1;
          mask  <= '0;
          state <= WAIT0;
        end
        default: state <= WAIT0;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: directed plus random scans of the 7-segment bus,
// scored against a dwell/frame-level model.
module tb_seg7_reader;

  localparam int STABLE = 4;
  localparam logic [6:0] BLK = 7'b1111111;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  b;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic [6:0]  nSeg;
  logic [3:0]  nDig;
  logic [15:0] dout;
  logic [3:0]  blank;
  logic        valid, err;

  always #5 clk = ~clk;

  seg7_reader #(.STABLE(STABLE)) dut (
    .CLK(clk), .RST(rst), .nSEG(nSeg), .nDIG(nDig), .CLR(clr),
    .DOUT(dout), .BLANK(blank), .VALID(valid), .ERR(err)
  );

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000};

  int checks = 0;
  int failures = 0;
  int validCnt = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: dwells -> acceptance events -> frames
  int          mState;
  logic [3:0]  mMask;
  logic [3:0]  mNib [4];
  logic        mBl [4];
  bit          mErr;
  logic [3:0]  curDig;
  logic [6:0]  curSeg;
  int          runLen;
  bit          taken;
  frame_t      mLast;
  frame_t      expQ [$];

  function automatic int decodeSeg(logic [6:0] s);
    if (s == BLK) return 10;
    for (int k = 0; k < 10; k++) if (pat[k] == s) return k;
    return -1;
  endfunction

  task automatic modelReset();
    mState = 0;
    mMask  = 0;
    for (int k = 0; k < 4; k++) begin
      mNib[k] = 0;
      mBl[k]  = 0;
    end
    mErr   = 0;
    curDig = 4'hF;
    curSeg = BLK;
    runLen = 0;
    taken  = 0;
    mLast  = '{16'h0, 4'h0};
    expQ.delete();
  endtask

  task automatic modelEvent(int i, logic [6:0] s);
    int v;
    frame_t f;
    v = decodeSeg(s);
    if (v < 0) begin
      mErr = 1;
      return;
    end
    if (mState == 0 && i != 0) return;
    mNib[i] = (v == 10) ? 4'd0 : 4'(v);
    mBl[i]  = (v == 10);
    if (i == 0) begin
      mMask  = 4'b0001;
      mState = 1;
    end else begin
      mMask = mMask | 4'(1 << i);
      if (mMask == 4'hF) begin
        f.d = {mNib[3], mNib[2], mNib[1], mNib[0]};
        f.b = {mBl[3], mBl[2], mBl[1], mBl[0]};
        expQ.push_back(f);
        mLast  = f;
        mState = 0;
        mMask  = 0;
      end
    end
  endtask

  task automatic modelDwell(logic [3:0] dg, logic [6:0] sg, int len);
    int lows;
    if (dg == curDig && sg == curSeg) runLen += len;
    else begin
      curDig = dg;
      curSeg = sg;
      runLen = len;
      taken  = 0;
    end
    lows = $countones(~dg);
    if (lows > 1) mErr = 1;
    if (lows == 1 && !taken && runLen >= STABLE) begin
      taken = 1;
      for (int k = 0; k < 4; k++) if (!dg[k]) modelEvent(k, sg);
    end
  endtask

  task automatic dwell(logic [3:0] dg, logic [6:0] sg, int len);
    modelDwell(dg, sg, len);
    nDig = dg;
    nSeg = sg;
    repeat (len) @(negedge clk);
  endtask

  function automatic logic [3:0] sel(int i);
    return ~(4'(1 << i));
  endfunction

  task automatic show(int i, int v, int len);
    dwell(sel(i), (v == 10) ? BLK : pat[v], len);
  endtask

  task automatic idle(int n);
    dwell(4'hF, BLK, n);
  endtask

  always @(negedge clk) begin
    if (valid) begin
      validCnt++;
      if (expQ.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        frame_t f;
        f = expQ.pop_front();
        chk("frame_dout", dout, f.d);
        chk("frame_blank", blank, f.b);
      end
    end
  end

  initial begin
    int v0;
    rst  = 1'b1;
    clr  = 1'b0;
    nDig = 4'hF;
    nSeg = BLK;
    modelReset();
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_blank", blank, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(4);

    show(0, 3, 8); show(1, 2, 8); show(2, 5, 8); show(3, 9, 8);
    idle(10);
    chk("normal_dout", dout, 16'h9523);
    chk("normal_blank", blank, 0);
    chk("normal_err", err, 0);
    chk("normal_valids", validCnt, 1);

    show(0, 0, 8); show(1, 7, 3); show(1, 4, 8);
    show(2, 1, 8); show(3, 2, 8);
    idle(10);
    chk("glitch_digit1", dout[7:4], 4);

    v0 = validCnt;
    show(2, 2, 8); show(3, 10, 8); show(0, 1, 8);
    show(1, 0, 8); show(2, 2, 8); show(3, 10, 8);
    idle(10);
    chk("blank_dout", dout, 16'h0201);
    chk("blank_mask", blank, 4'b1000);
    chk("blank_valids", validCnt - v0, 1);

    v0 = validCnt;
    show(0, 5, 8); dwell(sel(1), 7'b0101010, 8);
    show(2, 6, 8); show(3, 7, 8);
    idle(10);
    chk("invalid_err", err, mErr);
    chk("invalid_novalid", validCnt - v0, 0);
    dwell(4'b1100, pat[0], 6);
    idle(10);
    chk("multihot_err", err, 1);

    clr = 1'b1;
    @(negedge clk);
    clr  = 1'b0;
    mErr = 0;
    idle(3);
    chk("clr_err", err, 0);

    modelDwell(4'b1100, BLK, 10);
    nDig = 4'b1100;
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("err_set_wins", err, 1);
    repeat (4) @(negedge clk);
    idle(10);

    show(0, 7, 8); show(1, 8, 8);
    idle(6);
    rst = 1'b1;
    modelReset();
    #1;
    chk("midrst_dout", dout, 0);
    chk("midrst_blank", blank, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    show(0, 4, 8); show(1, 3, 8); show(2, 2, 8); show(3, 1, 8);
    idle(10);
    chk("midrst_scan", dout, 16'h1234);

    v0 = validCnt;
    show(0, 1, 8); show(1, 5, 8); show(0, 6, 8);
    show(1, 5, 8); show(2, 3, 8); show(3, 8, 8);
    idle(10);
    chk("restart_valids", validCnt - v0, 1);
    chk("restart_digit0", dout[3:0], 6);

    for (int n = 0; n < 400; n++) begin
      int r, s, len;
      logic [3:0] dg;
      logic [6:0] sg;
      r = $urandom_range(0, 19);
      if (r < 2) dg = 4'hF;
      else if (r == 2) dg = ~(4'b0011 << $urandom_range(0, 2));
      else dg = sel($urandom_range(0, 3));
      s = $urandom_range(0, 15);
      if (s < 10) sg = pat[s];
      else if (s < 13) sg = BLK;
      else sg = 7'($urandom);
      len = $urandom_range(1, 10);
      dwell(dg, sg, len);
    end
    idle(12);
    chk("rand_err", err, mErr);
    chk("rand_pending", expQ.size(), 0);
    chk("rand_hold_dout", dout, mLast.d);
    chk("rand_hold_blank", blank, mLast.b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
